// File: rtl/chrono_pkg.sv
// Package: chrono_pkg
// Shared FSM state encoding, time field widths and count limits for the
// stopwatch controller and its time cascade.
package chrono_pkg;

    localparam int unsigned HOUR_W = 4;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MS_W   = 10;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd9;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MS_W-1:0]   MS_MAX   = 10'd999;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_OVERFLOW = 2'd3
    } chrono_state_e;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [SEC_W-1:0]  seconds;
        logic [MS_W-1:0]   ms;
    } chrono_time_t;

    // True when the count shows 9:59:59.999, the last representable value.
    function automatic logic time_at_max(input chrono_time_t t);
        return (t.hours == HOUR_MAX) && (t.minutes == MIN_MAX) &&
               (t.seconds == SEC_MAX) && (t.ms == MS_MAX);
    endfunction

endpackage

// File: rtl/chrono_time_cascade.sv
// Module: chrono_time_cascade
// Live H:MM:SS.mmm counter. Each tick advances one millisecond with carries
// ms -> s -> min -> h; at 9:59:59.999 ticks are ignored (no wrap).
module chrono_time_cascade
    import chrono_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_i,
    input  logic         clear_i,
    output chrono_time_t time_o,
    output logic         at_max_o
);

    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  minutes_q, minutes_d;
    logic [SEC_W-1:0]  seconds_q, seconds_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic              at_max;

    assign time_o   = '{hours: hours_q, minutes: minutes_q, seconds: seconds_q, ms: ms_q};
    assign at_max   = time_at_max(time_o);
    assign at_max_o = at_max;

    // Next count: clear wins, otherwise a tick increments with cascaded carries.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        ms_d      = ms_q;
        if (clear_i) begin
            hours_d   = '0;
            minutes_d = '0;
            seconds_d = '0;
            ms_d      = '0;
        end else if (tick_i && !at_max) begin
            if (ms_q == MS_MAX) begin
                ms_d = '0;
                if (seconds_q == SEC_MAX) begin
                    seconds_d = '0;
                    if (minutes_q == MIN_MAX) begin
                        minutes_d = '0;
                        hours_d   = hours_q + 1'b1;
                    end else begin
                        minutes_d = minutes_q + 1'b1;
                    end
                end else begin
                    seconds_d = seconds_q + 1'b1;
                end
            end else begin
                ms_d = ms_q + 1'b1;
            end
        end
    end

    // Count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            ms_q      <= '0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            ms_q      <= ms_d;
        end
    end

endmodule

// File: rtl/chrono_controller.sv
// Module: chrono_controller
// Stopwatch sequencer: run/pause/overflow FSM, millisecond prescaler, live
// count (chrono_time_cascade) and a frame-coherent snapshot on the outputs.
// Define CHRONO_LAP_EN to add the lap port and the snapshot freeze flag.
module chrono_controller
    import chrono_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_DIV    = CLK_FREQ_HZ / 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              frame_start,
`ifdef CHRONO_LAP_EN
    input  logic              lap,
`endif
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MS_W-1:0]   milliseconds,
    output logic              enable,
    output logic              running
);

    localparam int unsigned         PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    chrono_state_e      state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic               casc_tick;
    logic               at_max;
    logic               snap_en;
    chrono_time_t       live_time;
    chrono_time_t       snap_q;
    logic               enable_q;
    logic               running_q;

    // Only RUNNING advances time, so a start pulse landing on the terminal
    // prescaler value cannot produce a tick in that cycle.
    assign tick      = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
    assign casc_tick = tick && !clear;

    chrono_time_cascade u_cascade (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (casc_tick),
        .clear_i  (clear),
        .time_o   (live_time),
        .at_max_o (at_max)
    );

    // FSM next state: clear has priority over start_stop from any state.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (start_stop) state_d = ST_RUNNING;
                ST_RUNNING: begin
                    if (start_stop)         state_d = ST_PAUSED;
                    else if (tick && at_max) state_d = ST_OVERFLOW;
                end
                ST_PAUSED:   if (start_stop) state_d = ST_RUNNING;
                ST_OVERFLOW: state_d = ST_OVERFLOW;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler next value: advances only while RUNNING, holds its phase in PAUSED.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == ST_RUNNING) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // FSM state and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

`ifdef CHRONO_LAP_EN
    logic freeze_q, freeze_d;

    // Lap freeze: toggled by lap while RUNNING; a pause or clear unfreezes.
    always_comb begin
        freeze_d = freeze_q;
        if (clear) begin
            freeze_d = 1'b0;
        end else if (state_q == ST_RUNNING) begin
            if (start_stop)  freeze_d = 1'b0;
            else if (lap)    freeze_d = ~freeze_q;
        end
    end

    // Freeze flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) freeze_q <= 1'b0;
        else        freeze_q <= freeze_d;
    end

    assign snap_en = frame_start && !freeze_q;
`else
    assign snap_en = frame_start;
`endif

    // Output registers: snapshot takes the pre-tick live count on frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q    <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            if (snap_en)     snap_q   <= live_time;
            if (frame_start) enable_q <= 1'b1;
            running_q <= (state_d == ST_RUNNING);
        end
    end

    assign hours        = snap_q.hours;
    assign minutes      = snap_q.minutes;
    assign seconds      = snap_q.seconds;
    assign milliseconds = snap_q.ms;
    assign enable       = enable_q;
    assign running      = running_q;

endmodule

// File: tb/tb_chrono_controller.sv
// Testbench: tb_chrono_controller
// Directed scenarios for chrono_controller with TICK_DIV=4 (4 clocks per ms).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_chrono_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       frame_start = 1'b0;
`ifdef CHRONO_LAP_EN
    logic       lap = 1'b0;
`endif
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [9:0] milliseconds;
    logic       enable;
    logic       running;

    int n_vec = 0;
    int n_err = 0;

    chrono_controller #(.TICK_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_stop   (start_stop),
        .clear        (clear),
        .frame_start  (frame_start),
`ifdef CHRONO_LAP_EN
        .lap          (lap),
`endif
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .milliseconds (milliseconds),
        .enable       (enable),
        .running      (running)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [25:0] tv(input int h, input int m, input int s, input int ms);
        return {4'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic snap();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic preload(input int h, input int m, input int s, input int ms);
        force dut.u_cascade.hours_q   = 4'(h);
        force dut.u_cascade.minutes_q = 6'(m);
        force dut.u_cascade.seconds_q = 6'(s);
        force dut.u_cascade.ms_q      = 10'(ms);
        wait_clk(2);
        release dut.u_cascade.hours_q;
        release dut.u_cascade.minutes_q;
        release dut.u_cascade.seconds_q;
        release dut.u_cascade.ms_q;
    endtask

    task automatic test_reset();
        wait_clk(2);
        n_vec++;
        if ({hours, minutes, seconds, milliseconds, enable, running} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_in: got %0d:%0d:%0d.%0d en=%0b run=%0b want all 0",
                     hours, minutes, seconds, milliseconds, enable, running);
        end
        rst_n = 1'b1;
        wait_clk(3);
        n_vec++;
        if (enable !== 1'b0) begin
            n_err++;
            $display("FAIL reset_en_pre: got %0b want 0", enable);
        end
        snap();
        n_vec++;
        if (enable !== 1'b1) begin
            n_err++;
            $display("FAIL reset_en_post: got %0b want 1", enable);
        end
        snap();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_snap: got %0d:%0d:%0d.%0d want 0:0:0.0",
                     hours, minutes, seconds, milliseconds);
        end
    endtask

    task automatic test_start_1s();
        pulse_ss();
        wait_clk(4000);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL start_1s: got %0d:%0d:%0d.%0d want 0:0:1.0",
                     hours, minutes, seconds, milliseconds);
        end
        n_vec++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL start_running: got %0b want 1", running);
        end
        wait_clk(50);
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL start_hold: got %0d:%0d:%0d.%0d want 0:0:1.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
        n_vec++;
        if ({running, hours, minutes, seconds, milliseconds} !== {1'b0, tv(0, 0, 1, 0)}) begin
            n_err++;
            $display("FAIL clear_no_snap: got run=%0b %0d:%0d:%0d.%0d want run=0 0:0:1.0",
                     running, hours, minutes, seconds, milliseconds);
        end
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL clear_snap: got %0d:%0d:%0d.%0d want 0:0:0.0",
                     hours, minutes, seconds, milliseconds);
        end
    endtask

    task automatic test_pause_resume();
        pulse_ss();
        wait_clk(10);
        pulse_ss();
        n_vec++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL pause_running: got %0b want 0", running);
        end
        wait_clk(100);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 2)) begin
            n_err++;
            $display("FAIL pause_hold: got %0d:%0d:%0d.%0d want 0:0:0.2",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_ss();
        n_vec++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL resume_running: got %0b want 1", running);
        end
        wait_clk(2);
        pulse_ss();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 3)) begin
            n_err++;
            $display("FAIL resume_phase: got %0d:%0d:%0d.%0d want 0:0:0.3",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
    endtask

    task automatic test_tick_snap();
        pulse_ss();
        wait_clk(3);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL tick_snap_pre: got %0d:%0d:%0d.%0d want 0:0:0.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_ss();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 1)) begin
            n_err++;
            $display("FAIL tick_snap_post: got %0d:%0d:%0d.%0d want 0:0:0.1",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
    endtask

    task automatic test_carry();
        preload(0, 59, 59, 999);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 59, 59, 999)) begin
            n_err++;
            $display("FAIL carry_preload: got %0d:%0d:%0d.%0d want 0:59:59.999",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_ss();
        wait_clk(4);
        pulse_ss();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(1, 0, 0, 0)) begin
            n_err++;
            $display("FAIL carry_hour: got %0d:%0d:%0d.%0d want 1:0:0.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
    endtask

    task automatic test_overflow();
        preload(9, 59, 59, 998);
        pulse_ss();
        wait_clk(7);
        n_vec++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_before: got run=%0b want 1", running);
        end
        wait_clk(1);
        n_vec++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_enter: got run=%0b want 0", running);
        end
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(9, 59, 59, 999)) begin
            n_err++;
            $display("FAIL ovf_value: got %0d:%0d:%0d.%0d want 9:59:59.999",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_ss();
        wait_clk(8);
        snap();
        n_vec++;
        if ({running, hours, minutes, seconds, milliseconds} !== {1'b0, tv(9, 59, 59, 999)}) begin
            n_err++;
            $display("FAIL ovf_ignore_ss: got run=%0b %0d:%0d:%0d.%0d want run=0 9:59:59.999",
                     running, hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
        snap();
        n_vec++;
        if ({running, hours, minutes, seconds, milliseconds} !== {1'b0, tv(0, 0, 0, 0)}) begin
            n_err++;
            $display("FAIL ovf_clear: got run=%0b %0d:%0d:%0d.%0d want run=0 0:0:0.0",
                     running, hours, minutes, seconds, milliseconds);
        end
        pulse_ss();
        n_vec++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_idle_start: got run=%0b want 1", running);
        end
        pulse_clr();
    endtask

    task automatic test_clear_and_start();
        pulse_ss();
        wait_clk(10);
        clear      = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        start_stop = 1'b0;
        n_vec++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ss_running: got %0b want 0", running);
        end
        wait_clk(8);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL clr_ss_idle: got %0d:%0d:%0d.%0d want 0:0:0.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_ss();
        wait_clk(2);
        pulse_ss();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL clr_ss_presc: got %0d:%0d:%0d.%0d want 0:0:0.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
    endtask

    task automatic test_mid_reset();
        pulse_ss();
        wait_clk(20);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 0, 5)) begin
            n_err++;
            $display("FAIL midrst_pre: got %0d:%0d:%0d.%0d want 0:0:0.5",
                     hours, minutes, seconds, milliseconds);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({hours, minutes, seconds, milliseconds, enable, running} !== 28'd0) begin
            n_err++;
            $display("FAIL midrst_async: got %0d:%0d:%0d.%0d en=%0b run=%0b want all 0",
                     hours, minutes, seconds, milliseconds, enable, running);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(12);
        snap();
        n_vec++;
        if ({running, hours, minutes, seconds, milliseconds} !== {1'b0, tv(0, 0, 0, 0)}) begin
            n_err++;
            $display("FAIL midrst_idle: got run=%0b %0d:%0d:%0d.%0d want run=0 0:0:0.0",
                     running, hours, minutes, seconds, milliseconds);
        end
    endtask

`ifdef CHRONO_LAP_EN
    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
    endtask

    task automatic test_lap();
        pulse_ss();
        wait_clk(4000);
        snap();
        pulse_lap();
        wait_clk(3998);
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL lap_frozen: got %0d:%0d:%0d.%0d want 0:0:1.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_lap();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 2, 0)) begin
            n_err++;
            $display("FAIL lap_release: got %0d:%0d:%0d.%0d want 0:0:2.0",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_lap();
        pulse_ss();
        snap();
        n_vec++;
        if ({hours, minutes, seconds, milliseconds} !== tv(0, 0, 2, 1)) begin
            n_err++;
            $display("FAIL lap_pause_unfreeze: got %0d:%0d:%0d.%0d want 0:0:2.1",
                     hours, minutes, seconds, milliseconds);
        end
        pulse_clr();
    endtask
`endif

    initial begin
        test_reset();
        test_start_1s();
        test_pause_resume();
        test_tick_snap();
        test_carry();
        test_overflow();
        test_clear_and_start();
        test_mid_reset();
`ifdef CHRONO_LAP_EN
        test_lap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
